frv_interrupt_ctrl: RTL and testbench



---
 rtl/frv_common.sv | 15 +
 rtl/frv_interrupt_ctrl_if.sv | 50 +++++
 rtl/frv_int_prio_arb.sv | 34 +++
 rtl/frv_interrupt_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_frv_interrupt_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frv_common.sv
// Shared FRV definitions: interrupt cause codes and the interrupt-controller
// request FSM encoding.
package frv_common;

  localparam logic [5:0] TRAP_INT_NONE = 6'd0;
  localparam logic [5:0] TRAP_INT_MSI  = 6'd3;
  localparam logic [5:0] TRAP_INT_MTI  = 6'd7;
  localparam logic [5:0] TRAP_INT_MEI  = 6'd11;

  typedef enum logic [0:0] {
    INT_ST_IDLE = 1'b0,
    INT_ST_REQ  = 1'b1
  } int_state_e;

endpackage

// File: rtl/frv_interrupt_ctrl_if.sv
// Signal bundle between the CSR/WB side (master) and the interrupt
// controller (slave).
interface frv_interrupt_ctrl_if #(
  parameter int NUM_EXT = 8,
  parameter int PRIO_W  = 3,
  parameter int IDX_W   = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1
);

  logic               mstatus_mie;
  logic               mie_meie;
  logic               mie_mtie;
  logic               mie_msie;
  logic               ti_pending;
  logic               sw_pending;
  logic [NUM_EXT-1:0] ext_irq;
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_idx;
  logic               cfg_en;
  logic               cfg_edge;
  logic [PRIO_W-1:0]  cfg_prio;
  logic               thr_we;
  logic [PRIO_W-1:0]  thr_wdata;
  logic               mip_meip;
  logic               mip_mtip;
  logic               mip_msip;
  logic [NUM_EXT-1:0] ext_pending;
  logic               int_trap_req;
  logic [5:0]         int_trap_cause;
  logic [IDX_W-1:0]   int_trap_id;
  logic               int_trap_ack;

  modport master (
    output mstatus_mie, mie_meie, mie_mtie, mie_msie,
    output ti_pending, sw_pending, ext_irq,
    output cfg_we, cfg_idx, cfg_en, cfg_edge, cfg_prio,
    output thr_we, thr_wdata, int_trap_ack,
    input  mip_meip, mip_mtip, mip_msip, ext_pending,
    input  int_trap_req, int_trap_cause, int_trap_id
  );

  modport slave (
    input  mstatus_mie, mie_meie, mie_mtie, mie_msie,
    input  ti_pending, sw_pending, ext_irq,
    input  cfg_we, cfg_idx, cfg_en, cfg_edge, cfg_prio,
    input  thr_we, thr_wdata, int_trap_ack,
    output mip_meip, mip_mtip, mip_msip, ext_pending,
    output int_trap_req, int_trap_cause, int_trap_id
  );

endinterface

// File: rtl/frv_int_prio_arb.sv
// Combinational N-way arbiter: picks the valid input with the highest
// priority, lowest index on ties.
module frv_int_prio_arb #(
  parameter int N      = 8,
  parameter int PRIO_W = 3,
  parameter int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]        i_valid,
  input  logic [N*PRIO_W-1:0] i_prio,
  output logic                o_any,
  output logic [IDX_W-1:0]    o_idx,
  output logic [PRIO_W-1:0]   o_prio
);

  logic [PRIO_W-1:0] w_cand;
  logic              w_take;

  // strict '>' keeps the earlier (lower) index when priorities tie
  always_comb begin
    o_any  = 1'b0;
    o_idx  = '0;
    o_prio = '0;
    w_cand = '0;
    w_take = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_cand = i_prio[i*PRIO_W +: PRIO_W];
      w_take = i_valid[i] && (w_cand > o_prio);
      o_any  = o_any || w_take;
      o_idx  = w_take ? IDX_W'(i) : o_idx;
      o_prio = w_take ? w_cand : o_prio;
    end
  end

endmodule

// File: rtl/frv_interrupt_ctrl.sv
// FRV machine-mode interrupt controller: per-line pending/config, threshold,
// external arbitration and a registered trap request handshake towards WB.
module frv_interrupt_ctrl
  import frv_common::*;
#(
  parameter int  NUM_EXT = 8,
  parameter int  PRIO_W  = 3,
  localparam int IDX_W   = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1
) (
  input logic                 g_clk,
  input logic                 g_reset,
  frv_interrupt_ctrl_if.slave io_bus
);

  logic [NUM_EXT-1:0]        w_pend;
  logic [NUM_EXT-1:0]        w_elig;
  logic [NUM_EXT*PRIO_W-1:0] w_prio_flat;

  logic [PRIO_W-1:0] r_thr;
  logic              r_mtip;
  logic              r_msip;

  int_state_e        r_state;
  int_state_e        w_state_nxt;
  logic              r_req;
  logic              w_req_nxt;
  logic [5:0]        r_cause;
  logic [5:0]        w_cause_nxt;
  logic [IDX_W-1:0]  r_id;
  logic [IDX_W-1:0]  w_id_nxt;

  logic              w_arb_any;
  logic [IDX_W-1:0]  w_arb_idx;
  logic [PRIO_W-1:0] w_arb_prio;

  logic w_meip;
  logic w_mei_raise;
  logic w_mti_raise;
  logic w_msi_raise;
  logic w_src_live;
  logic w_claim;

  assign w_claim = (r_state == INT_ST_REQ) && io_bus.int_trap_ack &&
                   (r_cause == TRAP_INT_MEI);

  for (genvar g = 0; g < NUM_EXT; g++) begin : g_line
    logic              r_pend;
    logic              r_hist;
    logic              r_en;
    logic              r_edge;
    logic [PRIO_W-1:0] r_prio;
    logic              w_cfg_hit;
    logic              w_rise;
    logic              w_ack_clr;

    assign w_cfg_hit = io_bus.cfg_we && (io_bus.cfg_idx == IDX_W'(g));
    assign w_rise    = io_bus.ext_irq[g] && !r_hist;
    assign w_ack_clr = w_claim && (r_id == IDX_W'(g));

    // a fresh edge outranks the ack clear so an edge in the ack cycle is kept
    always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
        r_pend <= 1'b0;
        r_hist <= 1'b0;
        r_en   <= 1'b0;
        r_edge <= 1'b0;
        r_prio <= '0;
      end else if (w_cfg_hit) begin
        r_pend <= 1'b0;
        r_hist <= 1'b0;
        r_en   <= io_bus.cfg_en;
        r_edge <= io_bus.cfg_edge;
        r_prio <= io_bus.cfg_prio;
      end else begin
        r_hist <= io_bus.ext_irq[g];
        if (r_edge) begin
          r_pend <= w_rise || (r_pend && !w_ack_clr);
        end else begin
          r_pend <= io_bus.ext_irq[g];
        end
      end
    end

    assign w_pend[g]                      = r_pend;
    assign w_elig[g]                      = r_pend && r_en && (r_prio > r_thr);
    assign w_prio_flat[g*PRIO_W +: PRIO_W] = r_prio;
  end

  frv_int_prio_arb #(
    .N      (NUM_EXT),
    .PRIO_W (PRIO_W),
    .IDX_W  (IDX_W)
  ) u_arb (
    .i_valid (w_elig),
    .i_prio  (w_prio_flat),
    .o_any   (w_arb_any),
    .o_idx   (w_arb_idx),
    .o_prio  (w_arb_prio)
  );

  // priority 0 can never interrupt, whatever the threshold
  assign w_meip      = w_arb_any && (w_arb_prio != '0);
  assign w_mei_raise = io_bus.mstatus_mie && io_bus.mie_meie && w_meip;
  assign w_mti_raise = io_bus.mstatus_mie && io_bus.mie_mtie && r_mtip;
  assign w_msi_raise = io_bus.mstatus_mie && io_bus.mie_msie && r_msip;

  // is the source captured in REQ still asking for the trap
  always_comb begin
    w_src_live = 1'b0;
    case (r_cause)
      TRAP_INT_MEI: w_src_live = io_bus.mstatus_mie && io_bus.mie_meie && w_elig[r_id];
      TRAP_INT_MTI: w_src_live = w_mti_raise;
      TRAP_INT_MSI: w_src_live = w_msi_raise;
      default:      w_src_live = 1'b0;
    endcase
  end

  // request FSM next-state; cause/ID are frozen while in REQ
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_cause_nxt = r_cause;
    w_id_nxt    = r_id;
    case (r_state)
      INT_ST_IDLE: begin
        if (w_mei_raise) begin
          w_state_nxt = INT_ST_REQ;
          w_req_nxt   = 1'b1;
          w_cause_nxt = TRAP_INT_MEI;
          w_id_nxt    = w_arb_idx;
        end else if (w_mti_raise) begin
          w_state_nxt = INT_ST_REQ;
          w_req_nxt   = 1'b1;
          w_cause_nxt = TRAP_INT_MTI;
          w_id_nxt    = '0;
        end else if (w_msi_raise) begin
          w_state_nxt = INT_ST_REQ;
          w_req_nxt   = 1'b1;
          w_cause_nxt = TRAP_INT_MSI;
          w_id_nxt    = '0;
        end else begin
          w_state_nxt = INT_ST_IDLE;
          w_req_nxt   = 1'b0;
        end
      end
      INT_ST_REQ: begin
        if (io_bus.int_trap_ack || !w_src_live) begin
          w_state_nxt = INT_ST_IDLE;
          w_req_nxt   = 1'b0;
          w_cause_nxt = TRAP_INT_NONE;
          w_id_nxt    = '0;
        end else begin
          w_state_nxt = INT_ST_REQ;
          w_req_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = INT_ST_IDLE;
        w_req_nxt   = 1'b0;
        w_cause_nxt = TRAP_INT_NONE;
        w_id_nxt    = '0;
      end
    endcase
  end

  // FSM state and registered trap outputs
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_state <= INT_ST_IDLE;
      r_req   <= 1'b0;
      r_cause <= TRAP_INT_NONE;
      r_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_cause <= w_cause_nxt;
      r_id    <= w_id_nxt;
    end
  end

  // threshold register and timer/software pending capture
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_thr  <= '0;
      r_mtip <= 1'b0;
      r_msip <= 1'b0;
    end else begin
      if (io_bus.thr_we) begin
        r_thr <= io_bus.thr_wdata;
      end else begin
        r_thr <= r_thr;
      end
      r_mtip <= io_bus.ti_pending;
      r_msip <= io_bus.sw_pending;
    end
  end

  assign io_bus.mip_meip       = w_meip;
  assign io_bus.mip_mtip       = r_mtip;
  assign io_bus.mip_msip       = r_msip;
  assign io_bus.ext_pending    = w_pend;
  assign io_bus.int_trap_req   = r_req;
  assign io_bus.int_trap_cause = r_cause;
  assign io_bus.int_trap_id    = r_id;

endmodule

// File: tb/tb_frv_interrupt_ctrl.sv
// Bench for frv_interrupt_ctrl: directed scenarios plus random traffic, all
// compared each cycle against a behavioural model of the controller.
module tb_frv_interrupt_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  frv_interrupt_ctrl_if #(.NUM_EXT(8), .PRIO_W(3)) bus ();

  frv_interrupt_ctrl #(.NUM_EXT(8), .PRIO_W(3)) dut (
    .g_clk   (clk),
    .g_reset (rst),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model state
  bit m_en   [8];
  bit m_edge [8];
  int m_prio [8];
  bit m_pend [8];
  bit m_hist [8];
  int m_thr;
  bit m_mtip;
  bit m_msip;
  bit m_req;
  int m_cause;
  int m_id;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_en[i] = 0; m_edge[i] = 0; m_prio[i] = 0; m_pend[i] = 0; m_hist[i] = 0;
    end
    m_thr = 0; m_mtip = 0; m_msip = 0; m_req = 0; m_cause = 0; m_id = 0;
  endtask

  function automatic bit eligible(int i);
    return m_pend[i] && m_en[i] && (m_prio[i] > m_thr);
  endfunction

  // search from the top priority down, scanning lines low to high
  function automatic int winner();
    for (int p = 7; p >= 1; p--)
      for (int i = 0; i < 8; i++)
        if (eligible(i) && m_prio[i] == p) return i;
    return -1;
  endfunction

  function automatic bit still_live();
    if (m_cause == 11) return bus.mstatus_mie && bus.mie_meie && eligible(m_id);
    if (m_cause == 7)  return bus.mstatus_mie && bus.mie_mtie && m_mtip;
    if (m_cause == 3)  return bus.mstatus_mie && bus.mie_msie && m_msip;
    return 0;
  endfunction

  function automatic bit any_meip();
    return winner() >= 0;
  endfunction

  task automatic model_step();
    int w;
    int clr;
    bit nreq;
    int ncause;
    int nid;
    w = winner();
    nreq = m_req; ncause = m_cause; nid = m_id;
    if (!m_req) begin
      if (bus.mstatus_mie && bus.mie_meie && w >= 0) begin
        nreq = 1; ncause = 11; nid = w;
      end else if (bus.mstatus_mie && bus.mie_mtie && m_mtip) begin
        nreq = 1; ncause = 7; nid = 0;
      end else if (bus.mstatus_mie && bus.mie_msie && m_msip) begin
        nreq = 1; ncause = 3; nid = 0;
      end
    end else if (bus.int_trap_ack || !still_live()) begin
      nreq = 0; ncause = 0; nid = 0;
    end
    clr = (m_req && bus.int_trap_ack && m_cause == 11) ? m_id : -1;
    for (int i = 0; i < 8; i++) begin
      if (bus.cfg_we && int'(bus.cfg_idx) == i) begin
        m_pend[i] = 0; m_hist[i] = 0;
        m_en[i] = bus.cfg_en; m_edge[i] = bus.cfg_edge; m_prio[i] = int'(bus.cfg_prio);
      end else begin
        if (m_edge[i])
          m_pend[i] = (bus.ext_irq[i] && !m_hist[i]) || (m_pend[i] && i != clr);
        else
          m_pend[i] = bus.ext_irq[i];
        m_hist[i] = bus.ext_irq[i];
      end
    end
    if (bus.thr_we) m_thr = int'(bus.thr_wdata);
    m_mtip = bus.ti_pending;
    m_msip = bus.sw_pending;
    m_req = nreq; m_cause = ncause; m_id = nid;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] pv;
    for (int i = 0; i < 8; i++) pv[i] = m_pend[i];
    chk("req",         32'(bus.int_trap_req),   32'(m_req));
    chk("cause",       32'(bus.int_trap_cause), 32'(m_cause));
    chk("id",          32'(bus.int_trap_id),    32'(m_id));
    chk("ext_pending", 32'(bus.ext_pending),    32'(pv));
    chk("mip_meip",    32'(bus.mip_meip),       32'(any_meip()));
    chk("mip_mtip",    32'(bus.mip_mtip),       32'(m_mtip));
    chk("mip_msip",    32'(bus.mip_msip),       32'(m_msip));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic cfg_write(input int idx, input bit en, input bit edge_m, input int prio);
    bus.cfg_we = 1'b1; bus.cfg_idx = 3'(idx); bus.cfg_en = en;
    bus.cfg_edge = edge_m; bus.cfg_prio = 3'(prio);
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic thr_write(input int v);
    bus.thr_we = 1'b1; bus.thr_wdata = 3'(v);
    step();
    bus.thr_we = 1'b0;
  endtask

  task automatic do_ack();
    bus.int_trap_ack = 1'b1;
    step();
    bus.int_trap_ack = 1'b0;
  endtask

  task automatic wait_req(input int budget);
    int n;
    n = 0;
    while (!bus.int_trap_req && n < budget) begin
      step();
      n++;
    end
    chk("wait_req_timeout", 32'(bus.int_trap_req), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] flip;
    n_checks = 0; n_err = 0;
    rst = 1'b1;
    bus.mstatus_mie = 1'b0; bus.mie_meie = 1'b0; bus.mie_mtie = 1'b0; bus.mie_msie = 1'b0;
    bus.ti_pending = 1'b0; bus.sw_pending = 1'b0; bus.ext_irq = 8'h00;
    bus.cfg_we = 1'b0; bus.cfg_idx = 3'd0; bus.cfg_en = 1'b0; bus.cfg_edge = 1'b0;
    bus.cfg_prio = 3'd0; bus.thr_we = 1'b0; bus.thr_wdata = 3'd0; bus.int_trap_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    check_all();

    // reset configs are all zero: level lines pend but never interrupt
    bus.mstatus_mie = 1'b1; bus.mie_meie = 1'b1;
    bus.ext_irq = 8'hFF;
    repeat (3) step();
    chk("rst_cfg_meip", 32'(bus.mip_meip), 32'd0);
    chk("rst_cfg_pend", 32'(bus.ext_pending), 32'hFF);
    bus.ext_irq = 8'h00;
    step();

    // arbitration: tie at prio 5 goes to line 2, then line 6 at prio 7 wins
    cfg_write(2, 1, 0, 5);
    cfg_write(6, 1, 0, 5);
    bus.ext_irq[2] = 1'b1; bus.ext_irq[6] = 1'b1;
    wait_req(6);
    chk("arb_tie_cause", 32'(bus.int_trap_cause), 32'd11);
    chk("arb_tie_id", 32'(bus.int_trap_id), 32'd2);
    cfg_write(6, 1, 0, 7);
    do_ack();
    wait_req(6);
    chk("arb_hi_id", 32'(bus.int_trap_id), 32'd6);
    bus.ext_irq = 8'h00;
    do_ack();
    step();
    cfg_write(2, 0, 0, 0);
    cfg_write(6, 0, 0, 0);

    // edge capture, including a second edge landing in the ack cycle
    cfg_write(3, 1, 1, 4);
    bus.ext_irq[3] = 1'b1;
    step();
    chk("edge_pend_set", 32'(bus.ext_pending[3]), 32'd1);
    chk("edge_req_lat1", 32'(bus.int_trap_req), 32'd0);
    bus.ext_irq[3] = 1'b0;
    step();
    chk("edge_req_lat2", 32'(bus.int_trap_req), 32'd1);
    chk("edge_id", 32'(bus.int_trap_id), 32'd3);
    repeat (3) step();
    chk("edge_pend_hold", 32'(bus.ext_pending[3]), 32'd1);
    bus.ext_irq[3] = 1'b1;
    do_ack();
    chk("edge_in_ack_pend", 32'(bus.ext_pending[3]), 32'd1);
    chk("edge_ack_req_low", 32'(bus.int_trap_req), 32'd0);
    bus.ext_irq[3] = 1'b0;
    wait_req(6);
    chk("edge_second_id", 32'(bus.int_trap_id), 32'd3);
    do_ack();
    chk("edge_ack_clear", 32'(bus.ext_pending[3]), 32'd0);
    cfg_write(3, 0, 0, 0);

    // threshold: prio equal to threshold is blocked, lowering it releases
    cfg_write(1, 1, 0, 3);
    thr_write(3);
    bus.ext_irq[1] = 1'b1;
    repeat (4) step();
    chk("thr_block_req", 32'(bus.int_trap_req), 32'd0);
    chk("thr_block_meip", 32'(bus.mip_meip), 32'd0);
    thr_write(2);
    chk("thr_open_meip", 32'(bus.mip_meip), 32'd1);
    step();
    chk("thr_open_req", 32'(bus.int_trap_req), 32'd1);
    bus.ext_irq[1] = 1'b0;
    do_ack();
    step();
    cfg_write(1, 0, 0, 0);
    thr_write(0);

    // class order MEI > MTI > MSI
    bus.mie_mtie = 1'b1; bus.mie_msie = 1'b1;
    cfg_write(5, 1, 1, 2);
    bus.ti_pending = 1'b1; bus.sw_pending = 1'b1; bus.ext_irq[5] = 1'b1;
    step();
    bus.ext_irq[5] = 1'b0;
    wait_req(6);
    chk("class_1st", 32'(bus.int_trap_cause), 32'd11);
    do_ack();
    wait_req(6);
    chk("class_2nd", 32'(bus.int_trap_cause), 32'd7);
    bus.ti_pending = 1'b0;
    do_ack();
    wait_req(6);
    chk("class_3rd", 32'(bus.int_trap_cause), 32'd3);
    bus.sw_pending = 1'b0;
    do_ack();
    step();
    cfg_write(5, 0, 0, 0);

    // withdrawal when mstatus_mie drops, and a later ack is ignored
    bus.ti_pending = 1'b1;
    wait_req(6);
    chk("wd_cause", 32'(bus.int_trap_cause), 32'd7);
    bus.mstatus_mie = 1'b0;
    step();
    chk("wd_req_low", 32'(bus.int_trap_req), 32'd0);
    do_ack();
    chk("wd_ack_ignored", 32'(bus.int_trap_req), 32'd0);
    bus.ti_pending = 1'b0;
    repeat (2) step();
    bus.mstatus_mie = 1'b1;
    step();

    // asynchronous reset in the middle of REQ
    cfg_write(0, 1, 0, 1);
    bus.ext_irq[0] = 1'b1; bus.ti_pending = 1'b1;
    wait_req(6);
    chk("pre_rst_cause", 32'(bus.int_trap_cause), 32'd11);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_req", 32'(bus.int_trap_req), 32'd0);
    chk("rst_cause", 32'(bus.int_trap_cause), 32'd0);
    chk("rst_id", 32'(bus.int_trap_id), 32'd0);
    chk("rst_pend", 32'(bus.ext_pending), 32'd0);
    chk("rst_mip", 32'({bus.mip_meip, bus.mip_mtip, bus.mip_msip}), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    step();
    chk("rst_cfg0_meip", 32'(bus.mip_meip), 32'd0);
    bus.ti_pending = 1'b0; bus.ext_irq = 8'h00;
    repeat (2) step();

    // random traffic against the model
    for (int k = 0; k < 800; k++) begin
      flip = 8'($urandom & $urandom & $urandom);
      bus.ext_irq = bus.ext_irq ^ flip;
      bus.cfg_we = ($urandom_range(0, 9) == 0);
      bus.cfg_idx = 3'($urandom_range(0, 7));
      bus.cfg_en = ($urandom_range(0, 3) != 0);
      bus.cfg_edge = 1'($urandom);
      bus.cfg_prio = 3'($urandom);
      bus.thr_we = ($urandom_range(0, 19) == 0);
      bus.thr_wdata = 3'($urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) bus.ti_pending = ~bus.ti_pending;
      if ($urandom_range(0, 7) == 0) bus.sw_pending = ~bus.sw_pending;
      bus.mstatus_mie = ($urandom_range(0, 15) != 0);
      bus.mie_meie = ($urandom_range(0, 7) != 0);
      bus.mie_mtie = ($urandom_range(0, 3) != 0);
      bus.mie_msie = ($urandom_range(0, 3) != 0);
      bus.int_trap_ack = bus.int_trap_req ? ($urandom_range(0, 2) == 0)
                                          : ($urandom_range(0, 7) == 0);
      step();
    end
    bus.cfg_we = 1'b0; bus.thr_we = 1'b0; bus.int_trap_ack = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
